inst_sram_axi_bridge: RTL and testbench
=======================================

# inst_sram_axi_bridge

Instruction-side responder for the CPU's SRAM-like fetch interface. It accepts one fetch request at a time from the pre-IF/IF stages and converts it into a single-beat AXI read. It returns the instruction word with a one-cycle `inst_sram_data_ok` pulse. It sits between the CPU core and the AXI interconnect and is the data source behind `inst_sram_rdata`/`inst_sram_data_ok`.

## Interface
Parameters:
- `AXI_ID`, default 4'd0, constant value driven on `arid`; `rid` is not checked.

Ports:
- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `inst_sram_req` input 1: fetch request valid.
- `inst_sram_size` input 2: access size (0=byte, 1=half, 2=word); fetch always uses 2.
- `inst_sram_addr` input 32: fetch address (physical).
- `inst_sram_addr_ok` output 1: request accepted this cycle when high together with `inst_sram_req`.
- `inst_sram_data_ok` output 1: one-cycle pulse, `inst_sram_rdata` is valid.
- `inst_sram_rdata` output 32: returned instruction word.
- `arid` output 4, `araddr` output 32, `arlen` output 8, `arsize` output 3, `arburst` output 2, `arlock` output 2, `arcache` output 4, `arprot` output 3, `arvalid` output 1, `arready` input 1: AXI read-address channel.
- `rid` input 4, `rdata` input 32, `rresp` input 2, `rlast` input 1, `rvalid` input 1, `rready` output 1: AXI read-data channel.

## Operation
- FSM with three states: IDLE, AR, R. Reset state is IDLE.
- IDLE: `inst_sram_addr_ok` = 1, combinational on the state only, not on `req`. If `inst_sram_req` is high:
  - latch `inst_sram_addr` into the address register;
  - latch `{1'b0, inst_sram_size}` into the size register;
  - go to AR.
- AR: `arvalid` = 1, `araddr`/`arsize` driven from the latched registers, which are stable while `arvalid` is high. `arvalid && arready` moves to R.
- R: `rready` = 1. `rvalid && rready` registers `rdata` into `inst_sram_rdata`, sets `inst_sram_data_ok` = 1 for exactly the next cycle, and returns to IDLE.
- Constant outputs:
  - `arid` = `AXI_ID`, `arlen` = 0, `arburst` = 2'b01;
  - `arlock` = 0, `arcache` = 0, `arprot` = 0.
- `rresp` and `rlast` are ignored; a single beat is always assumed.
- Outstanding-request limit is 1, and responses return in order by construction.
- `inst_sram_rdata` holds its last value until the next R handshake. The consumer samples it only while `data_ok` is high.
- The bridge has no flush input. A fetch that the core flushed still completes and pulses `data_ok`; discarding that data is the consumer's job.

## Timing
- Reset values:
  - `inst_sram_addr_ok` = 1, because the FSM is in IDLE;
  - `inst_sram_data_ok` = 0, `inst_sram_rdata` = 32'h0;
  - `arvalid` = 0, `rready` = 0, `araddr` = 32'h0, `arsize` = 3'd0.
- Request accepted at cycle T: `arvalid` is high from T+1.
- AR handshake at cycle A: `rready` is high from A+1.
- R handshake at cycle R: `data_ok` pulses at R+1 and `addr_ok` is high again at R+1. A new request can be accepted in the same cycle as `data_ok`.
- Minimum round trip, with `arready` and `rvalid` both high immediately: request at T, AR handshake at T+1, R handshake at T+2, `data_ok` at T+3. Throughput is one fetch per 3 cycles.
- `arvalid`, once asserted, stays high with stable `araddr` until `arready`; there is no withdrawal.
- `rvalid` seen outside state R: `rready` = 0, so there is no handshake and no state change.
- `inst_sram_req` while not in IDLE: `addr_ok` = 0, nothing is latched, and the request must be held by the initiator.
- `reset` mid-transaction: at the next edge the FSM is IDLE and `arvalid`/`rready`/`data_ok` are all 0. The in-flight AXI transaction is abandoned, because the AXI side is reset on the same signal.
- `data_ok` is never high for two consecutive cycles.

## Test plan
- Reset, then idle: hold `reset` 2 cycles and release -> `addr_ok`=1, `data_ok`=0, `arvalid`=0, `rready`=0, `rdata` out=0.
- Zero-wait fetch: `req`=1 with `addr`=0xBFC00000, `size`=2 at T, slave `arready`=1 and `rvalid`=1 with `rdata`=0x3C1D8000 always -> `arvalid`=1 with `araddr`=0xBFC00000 and `arsize`=2 at T+1; `data_ok`=1 with `rdata`=0x3C1D8000 at T+3; `addr_ok`=1 at T+3.
- Back-pressure: `arready` low for 4 cycles, then `rvalid` delayed 5 cycles -> `arvalid` and `araddr` stay stable for all 4 stall cycles. `addr_ok`=0 throughout. Exactly one `data_ok` pulse arrives 1 cycle after the R handshake.
- Back-to-back: `req` held high with addresses 0x1000, 0x1004, 0x1008 -> three AR transactions in order with correct `araddr`. Each `data_ok` carries the matching `rdata`. Each next request is accepted in the same cycle as the previous `data_ok`.
- Stray `rvalid`: `rvalid`=1 while in IDLE or AR -> `rready`=0, no `data_ok`, and the FSM state is unchanged.
- Reset during R: assert `reset` while waiting for `rvalid` -> next cycle is IDLE with `rready`=0 and no `data_ok`. A subsequent request to 0x2000 completes normally.

Source files
------------

// File: rtl/inst_sram_axi_bridge.sv
// inst_sram_axi_bridge: single-outstanding SRAM-like fetch port to single-beat AXI read bridge
module inst_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_n;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        unused_ok;
  assign unused_ok = ^{rid, rresp, rlast};
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && inst_sram_req) ? AR :
              (state == AR && arready)         ? R  :
              (state == R && rvalid)           ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      addr_q            <= 32'h0;
      size_q            <= 3'd0;
      inst_sram_rdata   <= 32'h0;
      inst_sram_data_ok <= 1'b0;
    end else begin
      state             <= state_n;
      inst_sram_data_ok <= state == R && rvalid;
      if (state == IDLE && inst_sram_req) begin
        addr_q <= inst_sram_addr;
        size_q <= {1'b0, inst_sram_size};
      end
      if (state == R && rvalid) inst_sram_rdata <= rdata;
    end
  end
  assign inst_sram_addr_ok = state == IDLE;
  assign arvalid = state == AR;
  assign rready  = state == R;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb_inst_sram_axi_bridge: directed checks of fetch latency, stalls, back-to-back and reset behaviour
module tb_inst_sram_axi_bridge;
  logic        clk = 0;
  logic        reset = 1;
  logic        req = 0;
  logic [1:0]  size = 2'd2;
  logic [31:0] addr = 32'h0;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, rready;
  logic        arready = 0;
  logic        rvalid = 0;
  logic [31:0] rdata = 32'h0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  inst_sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_size(size), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(4'd0), .rdata(rdata), .rresp(2'd0), .rlast(1'b1), .rvalid(rvalid), .rready(rready)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    tick();
    chk("rst_addr_ok", addr_ok, 1);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rdata", sram_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 0);
    chk("const_arlen", arlen, 0);
    chk("const_arburst", arburst, 1);
    chk("const_misc", {arid, arlock, arcache, arprot}, 0);
    // zero-wait fetch
    arready = 1; rvalid = 1; rdata = 32'h3C1D8000;
    req = 1; addr = 32'hBFC00000;
    tick();
    req = 0;
    chk("zw_arvalid", arvalid, 1);
    chk("zw_araddr", araddr, 32'hBFC00000);
    chk("zw_arsize", arsize, 2);
    chk("zw_addr_ok_busy", addr_ok, 0);
    tick();
    chk("zw_rready", rready, 1);
    chk("zw_data_ok_early", data_ok, 0);
    tick();
    chk("zw_data_ok", data_ok, 1);
    chk("zw_rdata", sram_rdata, 32'h3C1D8000);
    chk("zw_addr_ok", addr_ok, 1);
    tick();
    chk("zw_data_ok_once", data_ok, 0);
    // back-pressure
    arready = 0; rvalid = 0; rdata = 32'hCAFEF00D;
    req = 1; addr = 32'h0000_0100;
    tick();
    req = 0; addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      chk("bp_arvalid", arvalid, 1);
      chk("bp_araddr", araddr, 32'h0000_0100);
      chk("bp_addr_ok", addr_ok, 0);
      tick();
    end
    arready = 1;
    chk("bp_arvalid_hs", arvalid, 1);
    tick();
    arready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rready", rready, 1);
      chk("bp_no_data_ok", data_ok, 0);
      chk("bp_addr_ok_r", addr_ok, 0);
      tick();
    end
    rvalid = 1;
    tick();
    rvalid = 0;
    chk("bp_data_ok", data_ok, 1);
    chk("bp_rdata", sram_rdata, 32'hCAFEF00D);
    tick();
    chk("bp_data_ok_once", data_ok, 0);
    chk("bp_rdata_hold", sram_rdata, 32'hCAFEF00D);
    // back-to-back with req held high
    arready = 1; rvalid = 1;
    req = 1; addr = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      chk("b2b_addr_ok", addr_ok, 1);
      tick();
      chk("b2b_arvalid", arvalid, 1);
      chk("b2b_araddr", araddr, 32'h1000 + 32'(4 * i));
      addr = 32'h1000 + 32'(4 * (i + 1));
      if (i == 2) req = 0;
      rdata = 32'hA0000000 + 32'(i);
      tick();
      chk("b2b_rready", rready, 1);
      tick();
      chk("b2b_data_ok", data_ok, 1);
      chk("b2b_rdata", sram_rdata, 32'hA0000000 + 32'(i));
    end
    tick();
    chk("b2b_idle", arvalid, 0);
    chk("b2b_data_ok_off", data_ok, 0);
    // stray rvalid in IDLE and AR
    arready = 0; rvalid = 1; rdata = 32'h5555AAAA;
    chk("stray_idle_rready", rready, 0);
    tick();
    chk("stray_idle_data_ok", data_ok, 0);
    chk("stray_idle_addr_ok", addr_ok, 1);
    chk("stray_idle_arvalid", arvalid, 0);
    chk("stray_idle_rdata", sram_rdata, 32'hA0000002);
    req = 1; addr = 32'h3000;
    tick();
    req = 0;
    chk("stray_ar_rready", rready, 0);
    tick();
    chk("stray_ar_arvalid", arvalid, 1);
    chk("stray_ar_data_ok", data_ok, 0);
    chk("stray_ar_araddr", araddr, 32'h3000);
    arready = 1;
    tick();
    arready = 0;
    chk("stray_r_rready", rready, 1);
    tick();
    rvalid = 0;
    chk("stray_r_data_ok", data_ok, 1);
    chk("stray_r_rdata", sram_rdata, 32'h5555AAAA);
    // reset while waiting in R
    arready = 1; rvalid = 0;
    req = 1; addr = 32'h4000;
    tick();
    req = 0;
    tick();
    chk("rr_rready", rready, 1);
    reset = 1;
    tick();
    chk("rr_addr_ok", addr_ok, 1);
    chk("rr_rready_off", rready, 0);
    chk("rr_arvalid_off", arvalid, 0);
    chk("rr_data_ok", data_ok, 0);
    reset = 0;
    tick();
    chk("rr_data_ok2", data_ok, 0);
    rvalid = 1; rdata = 32'hDEADBEEF;
    req = 1; addr = 32'h2000;
    tick();
    req = 0;
    chk("rr2_araddr", araddr, 32'h2000);
    chk("rr2_arvalid", arvalid, 1);
    tick();
    tick();
    chk("rr2_data_ok", data_ok, 1);
    chk("rr2_rdata", sram_rdata, 32'hDEADBEEF);
    tick();
    chk("rr2_data_ok_once", data_ok, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
